// File: rtl/paddsb_seq_pkg.sv
// paddsb_seq_pkg
// Shared definitions for the nibble-parallel saturating adder.
// Contents:
//   state_t          FSM state encoding (IDLE, CALC, DONE)
//   LANES, LANE_W    lane count and lane width of the 16-bit datapath
//   SAT_POS, SAT_NEG lane values that replace an overflowed sum
package paddsb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LANES  = 4;
    localparam int LANE_W = 4;

    localparam logic [LANE_W-1:0] SAT_POS = 4'h7;
    localparam logic [LANE_W-1:0] SAT_NEG = 4'h8;

endpackage

// File: rtl/paddsb_seq_if.sv
// paddsb_seq_if
// Operand and result handshake between the stage controller and the adder.
// Signals:
//   in_valid / in_ready    operand handshake (a, b)
//   a, b                   four signed nibbles each
//   out_valid / out_ready  result handshake (out, sat)
//   out                    saturated lane sums
//   sat                    per-lane saturation flags
// Modports:
//   master  stage controller side
//   slave   adder side
interface paddsb_seq_if;
    import paddsb_seq_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*LANE_W-1:0]   a;
    logic [LANES*LANE_W-1:0]   b;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*LANE_W-1:0]   out;
    logic [LANES-1:0]          sat;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, sat
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, sat
    );

endinterface

// File: rtl/paddsb_seq_cla_4b.sv
// cla_4b
// 4-bit carry-lookahead adder, used as the single shared lane adder.
// Ports:
//   a, b  in  4  addends
//   cin   in  1  carry in
//   sum   out 4  a + b + cin (low 4 bits)
//   cout  out 1  carry out
//   pg    out 1  group propagate
//   gg    out 1  group generate
module cla_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       pg,
    output logic       gg
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead carries expanded from the generate/propagate terms.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign pg   = &p;
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    assign c[4] = gg | (pg & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/paddsb_seq.sv
// paddsb_seq
// Multi-cycle nibble-parallel saturating adder. Four signed 4-bit lanes are
// summed one per cycle through a shared cla_4b; each lane clamps to 7 / -8
// on signed overflow and reports it in sat.
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   bus    slave modport of paddsb_seq_if (operand/result handshakes)
module paddsb_seq
    import paddsb_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    paddsb_seq_if.slave  bus
);

    state_t                  state;
    logic [1:0]              idx;
    logic [LANES*LANE_W-1:0] a_q;
    logic [LANES*LANE_W-1:0] b_q;
    logic [LANES*LANE_W-1:0] out_q;
    logic [LANES-1:0]        sat_q;

    logic [LANE_W-1:0]       lane_a;
    logic [LANE_W-1:0]       lane_b;
    logic [LANE_W-1:0]       lane_s;
    logic [LANE_W-1:0]       lane_res;
    logic                    lane_sat;

    // Lane select: lane idx occupies bits [4*idx+3 : 4*idx].
    assign lane_a = a_q[{idx, 2'b00} +: LANE_W];
    assign lane_b = b_q[{idx, 2'b00} +: LANE_W];

    // Only the raw 4-bit sum is needed; overflow is detected from sign bits.
    cla_4b u_lane_add (
        .a    (lane_a),
        .b    (lane_b),
        .cin  (1'b0),
        .sum  (lane_s),
        .cout (),
        .pg   (),
        .gg   ()
    );

    // Signed overflow: operands share a sign and the sum's sign differs.
    always_comb begin
        lane_res = lane_s;
        lane_sat = 1'b0;
        if (!lane_a[LANE_W-1] && !lane_b[LANE_W-1] && lane_s[LANE_W-1]) begin
            lane_res = SAT_POS;
            lane_sat = 1'b1;
        end else if (lane_a[LANE_W-1] && lane_b[LANE_W-1] && !lane_s[LANE_W-1]) begin
            lane_res = SAT_NEG;
            lane_sat = 1'b1;
        end
    end

    // Control FSM plus the datapath registers it steers. Acceptance clears
    // the result so no lane of a previous operation survives; in_valid is
    // only looked at in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 2'd0;
            a_q   <= '0;
            b_q   <= '0;
            out_q <= '0;
            sat_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        out_q <= '0;
                        sat_q <= '0;
                        idx   <= 2'd0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    out_q[{idx, 2'b00} +: LANE_W] <= lane_res;
                    sat_q[idx]                    <= lane_sat;
                    idx                           <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs come straight from the state register.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out       = out_q;
    assign bus.sat       = sat_q;

endmodule

// File: tb/tb_paddsb_seq.sv
// tb_paddsb_seq
// Self-checking bench for paddsb_seq: a table of directed vectors, randomized
// operations against a per-lane integer clamp model, and sequences for
// backpressure and mid-operation reset.
module tb_paddsb_seq;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    paddsb_seq_if bus ();

    paddsb_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_out;
        logic [3:0]  exp_sat;
    } vec_t;

    vec_t vecs[4];

    // Reference: each lane is a signed integer sum clamped to [-8, 7].
    function automatic void refModel(input logic [15:0] a, input logic [15:0] b,
                                     output logic [15:0] o, output logic [3:0] s);
        logic signed [3:0] la;
        logic signed [3:0] lb;
        int sum;
        o = '0;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            la  = a[4*i +: 4];
            lb  = b[4*i +: 4];
            sum = int'(la) + int'(lb);
            if (sum > 7) begin
                sum  = 7;
                s[i] = 1'b1;
            end else if (sum < -8) begin
                sum  = -8;
                s[i] = 1'b1;
            end
            o[4*i +: 4] = sum[3:0];
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present operands for one edge; entered and left just after a negedge.
    task automatic startOp(input logic [15:0] a, input logic [15:0] b);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Counts edges after acceptance until out_valid is seen, with a bound.
    task automatic waitDone(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.out_valid && lat < 20);
        if (!bus.out_valid) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic finishOp();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("post_hs_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("post_hs_out_valid", {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] o, output logic [3:0] s, output int lat);
        checkOutput("pre_in_ready", {31'd0, bus.in_ready}, 32'd1);
        startOp(a, b);
        waitDone(lat);
        o = bus.out;
        s = bus.sat;
        finishOp();
    endtask

    initial begin
        logic [15:0] got_out;
        logic [3:0]  got_sat;
        logic [15:0] exp_out;
        logic [3:0]  exp_sat;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] held_out;
        logic [3:0]  held_sat;
        int          lat;

        total = 0;
        bad   = 0;

        vecs[0] = '{"basic",   16'h1234, 16'h1111, 16'h2345, 4'h0};
        vecs[1] = '{"pos_sat", 16'h7777, 16'h1111, 16'h7777, 4'hF};
        vecs[2] = '{"neg_sat", 16'h8888, 16'hFFFF, 16'h8888, 4'hF};
        vecs[3] = '{"mixed",   16'h783F, 16'h1F41, 16'h7870, 4'b1100};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        rst_n         = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("rst_out", {16'd0, bus.out}, 32'h0);
        checkOutput("rst_sat", {28'd0, bus.sat}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed vectors");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, got_out, got_sat, lat);
            checkOutput({vecs[i].name, "_out"}, {16'd0, got_out}, {16'd0, vecs[i].exp_out});
            checkOutput({vecs[i].name, "_sat"}, {28'd0, got_sat}, {28'd0, vecs[i].exp_sat});
            checkOutput({vecs[i].name, "_latency"}, lat, 32'd4);
        end

        $display("[TB] randomized operations");
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            refModel(ra, rb, exp_out, exp_sat);
            applyStimulus(ra, rb, got_out, got_sat, lat);
            checkOutput("rand_out", {16'd0, got_out}, {16'd0, exp_out});
            checkOutput("rand_sat", {28'd0, got_sat}, {28'd0, exp_sat});
        end

        $display("[TB] backpressure");
        startOp(16'h1234, 16'h7654);
        waitDone(lat);
        refModel(16'h1234, 16'h7654, exp_out, exp_sat);
        held_out = bus.out;
        held_sat = bus.sat;
        checkOutput("bp_out", {16'd0, held_out}, {16'd0, exp_out});
        checkOutput("bp_sat", {28'd0, held_sat}, {28'd0, exp_sat});
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.a = 16'h1111 * 16'(i + 1);
            bus.b = 16'h2222 + 16'(i);
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp_hold_out", {16'd0, bus.out}, {16'd0, held_out});
            checkOutput("bp_hold_sat", {28'd0, bus.sat}, {28'd0, held_sat});
            checkOutput("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            checkOutput("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("bp_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
        startOp(16'h4F27, 16'h5C39);
        waitDone(lat);
        refModel(16'h4F27, 16'h5C39, exp_out, exp_sat);
        checkOutput("bp_next_out", {16'd0, bus.out}, {16'd0, exp_out});
        checkOutput("bp_next_sat", {28'd0, bus.sat}, {28'd0, exp_sat});
        checkOutput("bp_next_latency", lat, 32'd4);
        finishOp();

        $display("[TB] reset mid-operation");
        startOp(16'h7777, 16'h1111);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out", {16'd0, bus.out}, 32'h0);
        checkOutput("mid_rst_sat", {28'd0, bus.sat}, 32'h0);
        checkOutput("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(16'h0101, 16'h0101, got_out, got_sat, lat);
        checkOutput("after_rst_out", {16'd0, got_out}, 32'h0202);
        checkOutput("after_rst_sat", {28'd0, got_sat}, 32'h0);
        checkOutput("after_rst_latency", lat, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/paddsb_seq.md
# paddsb_seq

Multi-cycle nibble-parallel saturating adder (PADDSB) for the execute stage. It is the distributing counterpart of the nibble reduction unit: instead of collapsing eight nibbles into one sum, it keeps four independent signed 4-bit lanes. Each lane sum is saturated, and the lanes are produced one per cycle through a single shared 4-bit adder. The block sits beside the ALU and talks to the stage controller over a valid/ready handshake.

## Interface
- No parameters. Lane count is 4 and lane width is 4; both are fixed by the 16-bit datapath.
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands a/b are valid this cycle
- in_ready  out  1  block can accept operands; high only in IDLE
- a  in  16  operand A, four signed nibbles, lane i = a[4i+3:4i]
- b  in  16  operand B, same layout
- out_valid  out  1  result and sat are valid
- out_ready  in  1  consumer takes the result this cycle
- out  out  16  saturated lane sums, lane i at out[4i+3:4i]
- sat  out  4  sat[i]=1 when lane i saturated

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - CALC: lane counter idx 0..3.
  - DONE: out_valid=1.
- IDLE→CALC on in_valid&&in_ready.
  - Latch a, b into operand registers.
  - Clear out and sat to 0; idx=0.
  - in_valid while not IDLE is ignored; operands are not sampled.
- CALC, each cycle:
  - Compute s = a_lane[idx] + b_lane[idx] with the 4-bit adder, cin=0.
  - Write the lane result to out[4idx+3:4idx] and the flag to sat[idx]; idx++.
  - After the idx=3 write, go to DONE.
- Saturation rule, signed two's complement per lane:
  - Both operands' MSB=0 and s MSB=1 → lane=4'h7, sat=1.
  - Both operands' MSB=1 and s MSB=0 → lane=4'h8, sat=1.
  - Otherwise lane=s, sat=0.
  - No carry crosses between lanes.
- DONE:
  - out and sat are held stable while out_ready=0.
  - DONE→IDLE on out_ready; out and sat keep their value until the next acceptance.
- No overlap: a new operation is accepted no earlier than the cycle after the result handshake.
- rst_n low at any time, including mid-CALC or DONE:
  - State goes to IDLE immediately and the partial result is discarded.
  - out=0, sat=0, idx=0, operand registers=0.

## Timing
- Reset values: out_valid=0, in_ready=1, out=16'h0000, sat=4'h0.
- Latency: acceptance at edge E0; lanes 0..3 are written at edges E1..E4; out_valid is high starting the cycle after E4, i.e. 4 cycles after acceptance.
- Throughput: at most one operation per 6 cycles (1 IDLE + 4 CALC + ≥1 DONE).
- in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid or out_ready.
- The result handshake completes on the edge where out_valid&&out_ready; in_ready rises in the following cycle.
- Intermediate lanes of out may be observed during CALC, but they are meaningful only when out_valid=1.

## Structure
- Shared package/include:
  - State encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - Constants LANES=4 and LANE_W=4.
  - Saturation constants SAT_POS=4'h7 and SAT_NEG=4'h8.
- Sub-module: reuse the existing cla_4b as the single lane adder, with pg/gg left unconnected.
  - Operand lanes come from a mux indexed by idx.
  - Saturation is a small combinational block in the top module.
- Everything else is one flat top module: FSM, 2-bit idx counter, operand registers, out/sat registers with lane-indexed write enable.

## Test plan
- a=16'h1234, b=16'h1111, out_ready=1 → out=16'h2345, sat=4'h0, out_valid first high 4 cycles after acceptance.
- Positive saturation: a=16'h7777, b=16'h1111 → out=16'h7777, sat=4'hF.
- Negative saturation: a=16'h8888, b=16'hFFFF → out=16'h8888, sat=4'hF.
- Mixed lanes: a=16'h783F, b=16'h1F41 → out=16'h7870, sat=4'b1100.
- Backpressure: out_ready=0 for 3 cycles in DONE with in_valid=1 and changing a/b:
  - out and sat stay stable and in_ready stays 0.
  - After out_ready=1, the next operation uses the operands presented when in_ready is high again.
- Reset mid-operation: drop rst_n during CALC idx=2:
  - out=0, sat=0, out_valid=0 and in_ready=1 asynchronously.
  - A following a=16'h0101, b=16'h0101 yields out=16'h0202 with no stale lanes.
